// File: rtl/serial_tx_block_if.sv
// serial_tx_block_if: word handshake between upstream logic and serial_tx_block.
//   tx_data  - word to transmit (DATA_BITS wide)
//   tx_valid - tx_data is valid
//   tx_ready - transmitter can accept a word this cycle
// Modports: master (upstream producer), slave (transmitter).
interface serial_tx_block_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/serial_tx_block.sv
// serial_tx_block: bit-serial asynchronous frame transmitter.
// Frame: start bit (0), DATA_BITS data bits LSB first, optional even parity bit, stop bit (1).
// Each bit lasts P cycles, P = bit_period_i latched at accept (0 is treated as 1).
// Optional feature macro: TX_PARITY_EN (defined = parity bit inserted before stop).
// Ports:
//   clk          - system clock
//   n_rst        - asynchronous active-low reset
//   abort_i      - synchronous frame abort, active high
//   bit_period_i - clock cycles per serial bit
//   tx_if        - slave side of the tx_data/tx_valid/tx_ready handshake
//   serial_out_o - serial line, idle high, registered
//   tx_busy_o    - frame in progress, registered
//   frame_done_o - one-cycle pulse after a frame completes, registered
module serial_tx_block #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CNT_BITS  = 14
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                abort_i,
    input  logic [CNT_BITS-1:0] bit_period_i,
    serial_tx_block_if.slave    tx_if,
    output logic                serial_out_o,
    output logic                tx_busy_o,
    output logic                frame_done_o
);

    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e               state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [CNT_BITS-1:0]  period_q, period_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 serial_q, serial_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic                 rollover;
    logic                 accept;
    logic                 last_bit;
    logic [DATA_BITS-1:0] shifted;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef TX_PARITY_EN
        parity_d = parity_q;
`endif

        rollover = (cnt_q == period_q);
        last_bit = (idx_q == IdxW'(DATA_BITS - 1));
        shifted  = shift_q >> 1;

        // Ready on the final stop cycle too, so back-to-back frames have no idle gap.
        tx_if.tx_ready = (state_q == StIdle) ||
                         ((state_q == StStop) && rollover && !abort_i);
        accept = tx_if.tx_valid && tx_if.tx_ready && !abort_i;

        if (abort_i) begin
            state_d  = StIdle;
            cnt_d    = '0;
            idx_d    = '0;
            serial_d = 1'b1;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: ;
                StStart: begin
                    if (rollover) begin
                        state_d  = StData;
                        cnt_d    = CNT_BITS'(1);
                        idx_d    = '0;
                        serial_d = shift_q[0];
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
                StData: begin
                    if (rollover) begin
                        cnt_d = CNT_BITS'(1);
                        if (last_bit) begin
`ifdef TX_PARITY_EN
                            state_d  = StParity;
                            serial_d = parity_q;
`else
                            state_d  = StStop;
                            serial_d = 1'b1;
`endif
                        end else begin
                            shift_d  = shifted;
                            idx_d    = idx_q + IdxW'(1);
                            serial_d = shifted[0];
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
`ifdef TX_PARITY_EN
                StParity: begin
                    if (rollover) begin
                        state_d  = StStop;
                        cnt_d    = CNT_BITS'(1);
                        serial_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
`endif
                StStop: begin
                    if (rollover) begin
                        done_d   = 1'b1;
                        state_d  = StIdle;
                        cnt_d    = '0;
                        serial_d = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
                default: begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                end
            endcase

            // Accept overrides the stop-to-idle transition for chained frames.
            if (accept) begin
                state_d  = StStart;
                cnt_d    = CNT_BITS'(1);
                period_d = (bit_period_i == '0) ? CNT_BITS'(1) : bit_period_i;
                shift_d  = tx_if.tx_data;
                idx_d    = '0;
                serial_d = 1'b0;
                busy_d   = 1'b1;
`ifdef TX_PARITY_EN
                parity_d = ^tx_if.tx_data;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            period_q <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign serial_out_o = serial_q;
    assign tx_busy_o    = busy_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_serial_tx_block.sv
// tb_serial_tx_block: self-checking bench for serial_tx_block.
// Expected line levels come from a frame model: bit slot n of a frame is
// start/data/parity/stop by position, each slot lasting P cycles.
module tb_serial_tx_block;

`ifdef TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk;
    logic        n_rst;
    logic        abort;
    logic [13:0] bit_period;
    logic        serial_out;
    logic        tx_busy;
    logic        frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    serial_tx_block_if #(.DATA_BITS(8)) tx_if ();

    serial_tx_block #(
        .DATA_BITS(8),
        .CNT_BITS (14)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .abort_i     (abort),
        .bit_period_i(bit_period),
        .tx_if       (tx_if),
        .serial_out_o(serial_out),
        .tx_busy_o   (tx_busy),
        .frame_done_o(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Line level for bit slot n of a frame carrying word w.
    function automatic logic exp_bit(input logic [7:0] w, input int n);
        if (n == 0) return 1'b0;
        if (n <= 8) return w[n-1];
`ifdef TX_PARITY_EN
        if (n == 9) return ^w;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge with the DUT idle; the accept happens at the next posedge.
    task automatic accept_word(input logic [7:0] w, input int bp);
        chk("ready_before_accept", tx_if.tx_ready, 1'b1);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = w;
        bit_period     = 14'(bp);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks a frame cycle by cycle starting at the negedge after its accept edge.
    // chain: present (nw, nbp) throughout so it is taken on the last stop cycle.
    // stop_kind 1 = abort at cycle stop_at, 2 = reset at cycle stop_at.
    task automatic run_frame(input logic [7:0] w, input int bp, input bit first_done,
                             input bit chain, input logic [7:0] nw, input int nbp,
                             input int stop_at, input int stop_kind);
        int p;
        int len;
        p   = (bp == 0) ? 1 : bp;
        len = NBITS * p;
        for (int k = 0; k < len; k++) begin
            chk("serial", serial_out, exp_bit(w, k / p));
            chk("busy", tx_busy, 1'b1);
            chk("done_in_frame", frame_done, (k == 0) && first_done);
            chk("ready_in_frame", tx_if.tx_ready, k == len - 1);
            if (k == stop_at) begin
                if (stop_kind == 1) begin
                    abort          = 1'b1;
                    tx_if.tx_valid = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    abort          = 1'b0;
                    tx_if.tx_valid = 1'b0;
                    chk("abort_serial", serial_out, 1'b1);
                    chk("abort_busy", tx_busy, 1'b0);
                    chk("abort_done", frame_done, 1'b0);
                    chk("abort_ready", tx_if.tx_ready, 1'b1);
                end else begin
                    tx_if.tx_valid = 1'b0;
                    n_rst = 1'b0;
                    #1;
                    chk("rst_serial", serial_out, 1'b1);
                    chk("rst_busy", tx_busy, 1'b0);
                    chk("rst_done", frame_done, 1'b0);
                    @(negedge clk);
                    n_rst = 1'b1;
                    @(negedge clk);
                    chk("rst_release_ready", tx_if.tx_ready, 1'b1);
                    chk("rst_release_done", frame_done, 1'b0);
                end
                return;
            end
            if (chain) begin
                tx_if.tx_valid = 1'b1;
                tx_if.tx_data  = nw;
                bit_period     = 14'(nbp);
            end else begin
                // Junk on the inputs must not disturb the frame in flight.
                tx_if.tx_valid = (k == len - 1) ? 1'b0 : 1'($urandom);
                tx_if.tx_data  = 8'($urandom);
                bit_period     = 14'($urandom_range(0, 15));
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (!chain) begin
            chk("done_pulse", frame_done, 1'b1);
            chk("idle_busy", tx_busy, 1'b0);
            chk("idle_serial", serial_out, 1'b1);
            chk("idle_ready", tx_if.tx_ready, 1'b1);
            @(posedge clk);
            @(negedge clk);
            chk("done_one_cycle", frame_done, 1'b0);
            chk("idle_busy2", tx_busy, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] w1;
        logic [7:0] w2;
        int         bp;
        n_rst          = 1'b1;
        abort          = 1'b0;
        bit_period     = 14'd4;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        chk("reset_serial", serial_out, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);
        chk("reset_done", frame_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("reset_ready", tx_if.tx_ready, 1'b1);
        chk("reset_serial_out", serial_out, 1'b1);

        // Basic frame.
        accept_word(8'hA5, 4);
        run_frame(8'hA5, 4, 1'b0, 1'b0, 8'h00, 0, -1, 0);

        // Back-to-back frames with no idle gap.
        accept_word(8'h01, 2);
        run_frame(8'h01, 2, 1'b0, 1'b1, 8'h80, 2, -1, 0);
        run_frame(8'h80, 2, 1'b1, 1'b0, 8'h00, 0, -1, 0);

        // Inputs change mid-frame (randomised junk inside run_frame).
        accept_word(8'hFF, 3);
        run_frame(8'hFF, 3, 1'b0, 1'b0, 8'h00, 0, -1, 0);

        // Abort in idle blocks the accept and has no other effect.
        abort          = 1'b1;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        abort          = 1'b0;
        tx_if.tx_valid = 1'b0;
        chk("idle_abort_busy", tx_busy, 1'b0);
        chk("idle_abort_serial", serial_out, 1'b1);
        chk("idle_abort_ready", tx_if.tx_ready, 1'b1);

        // Abort during data bit 3, then a clean frame.
        accept_word(8'h3C, 4);
        run_frame(8'h3C, 4, 1'b0, 1'b0, 8'h00, 0, 17, 1);
        accept_word(8'h55, 4);
        run_frame(8'h55, 4, 1'b0, 1'b0, 8'h00, 0, -1, 0);

        // Period 0 behaves as 1; then reset mid-frame.
        accept_word(8'h96, 0);
        run_frame(8'h96, 0, 1'b0, 1'b0, 8'h00, 0, -1, 0);
        accept_word(8'h96, 0);
        run_frame(8'h96, 0, 1'b0, 1'b0, 8'h00, 0, 5, 2);

        // Parity-relevant words (odd and even number of ones).
        accept_word(8'h07, 4);
        run_frame(8'h07, 4, 1'b0, 1'b0, 8'h00, 0, -1, 0);
        accept_word(8'h03, 4);
        run_frame(8'h03, 4, 1'b0, 1'b0, 8'h00, 0, -1, 0);

        // Random frames, some chained.
        for (int i = 0; i < 8; i++) begin
            w1 = 8'($urandom);
            w2 = 8'($urandom);
            bp = int'($urandom_range(0, 6));
            accept_word(w1, bp);
            if ($urandom_range(0, 1) == 1) begin
                run_frame(w1, bp, 1'b0, 1'b1, w2, bp, -1, 0);
                run_frame(w2, bp, 1'b1, 1'b0, 8'h00, 0, -1, 0);
            end else begin
                run_frame(w1, bp, 1'b0, 1'b0, 8'h00, 0, -1, 0);
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
